// File: rtl/ghist_sram_pkg.sv
// Shared types and helpers for the global-history SRAM front end.
// Holds default widths, the write-buffer entry type and youngest-match select.
package ghist_sram_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 128;
  localparam int WBUF_MAX   = 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wbuf_entry_t;

  // Returns {hit, idx}. Walks oldest to youngest from head,
  // so the last match found is the youngest one.
  function automatic logic [3:0] youngest_match(
    input logic [WBUF_MAX-1:0] match,
    input logic [2:0]          head,
    input int                  depth
  );
    logic [3:0] res;
    int         idx;
    logic [2:0] i3;
    res = '0;
    for (int k = 0; k < WBUF_MAX; k++) begin
      if (k < depth) begin
        idx = (int'(head) + k) % depth;
        i3  = 3'(idx);
        if (match[i3]) res = {1'b1, i3};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ghist_wbuf.sv
// Write buffer FIFO with address CAM and youngest-match data output.
// Ports: push/pop strobes, head entry, full/empty, lookup addr -> hit/hit_data.
module ghist_wbuf
  import ghist_sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] lkup_addr_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);

  logic [ADDR_W-1:0]   addr_q [WBUF_MAX];
  logic [DATA_W-1:0]   data_q [WBUF_MAX];
  logic [WBUF_MAX-1:0] vld_q, vld_d;
  logic [2:0]          head_q, head_d;
  logic [2:0]          tail_q, tail_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WBUF_MAX-1:0] match;
  logic [3:0]          sel;

  function automatic logic [2:0] nxt(input logic [2:0] p);
    return (p == 3'(DEPTH-1)) ? 3'd0 : p + 3'd1;
  endfunction

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = nxt(head_q);
    end
    if (push_i) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = nxt(tail_q);
    end
    cnt_d = 4'(cnt_q + {3'b0, push_i} - {3'b0, pop_i});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset: validity is tracked in vld_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Compare against registered entries only, so a same-cycle
  // enqueue never forwards to the read accepted alongside it.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld_q[i] && (addr_q[i] == lkup_addr_i);
    end
  end

  assign sel         = youngest_match(match, head_q, DEPTH);
  assign hit_o       = sel[3];
  assign hit_data_o  = data_q[sel[2:0]];
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign full_o      = (cnt_q == 4'(DEPTH));
  assign empty_o     = (cnt_q == 4'd0);

endmodule

// File: rtl/ghist_sram_ctrl.sv
// Single-port global-history SRAM controller: read/write arbitration,
// buffered writes with forwarding, one-cycle read response, sram_* macro pins.
module ghist_sram_ctrl
  import ghist_sram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              idle,
  output logic [ADDR_W-1:0] sram_A,
  output logic              sram_CSB,
  output logic              sram_WEB,
  output logic              sram_OEB,
  output logic [DATA_W-1:0] sram_I,
  input  logic [DATA_W-1:0] sram_O
);

  logic              full, empty, hit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, hit_data;
  logic              rd_acc, wr_acc, drain;

  logic              rsp_q, rsp_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] i_q, i_d;

  assign rd_req_ready = ~full;
  assign wr_req_ready = ~full;
  assign rd_acc       = rd_req_valid & ~full;
  assign wr_acc       = wr_req_valid & ~full;
  assign drain        = ~rd_acc & ~empty;

  ghist_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clock),
    .rst         (reset),
    .push_i      (wr_acc),
    .push_addr_i (wr_req_addr),
    .push_data_i (wr_req_data),
    .pop_i       (drain),
    .lkup_addr_i (rd_req_addr),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (full),
    .empty_o     (empty),
    .hit_o       (hit),
    .hit_data_o  (hit_data)
  );

  // Reads win the port; drains take idle slots. A/I hold otherwise.
  always_comb begin
    sram_CSB = ~(rd_acc | drain);
    sram_WEB = ~drain;
    sram_A   = a_q;
    sram_I   = i_q;
    if (rd_acc) begin
      sram_A = rd_req_addr;
    end else if (drain) begin
      sram_A = head_addr;
      sram_I = head_data;
    end
    a_d        = sram_A;
    i_d        = sram_I;
    rsp_d      = rd_acc;
    fwd_d      = rd_acc & hit;
    fwd_data_d = (rd_acc & hit) ? hit_data : fwd_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      a_q        <= '0;
      i_q        <= '0;
    end else begin
      rsp_q      <= rsp_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      a_q        <= a_d;
      i_q        <= i_d;
    end
  end

  assign sram_OEB     = ~rsp_q;
  assign rd_rsp_valid = rsp_q;
  assign rd_rsp_data  = !rsp_q ? '0 :
                        fwd_q  ? fwd_data_q : sram_O;
  assign idle         = empty & ~rsp_q;

endmodule
